pipe_lanes_elastic: RTL and testbench



---
 rtl/pcie_pl_pkg.sv | 13 +
 rtl/pipe_lanes_stage.sv | 37 +++
 rtl/pipe_lanes_elastic.sv | 108 ++++++++++
 tb/tb_pipe_lanes_elastic.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_pl_pkg.sv
// rtl/pcie_pl_pkg.sv - shared sizing defaults and helpers for PCIe PHY lane blocks
package pcie_pl_pkg;

  localparam int LANE_W_DEFAULT = 8;
  localparam int DEFAULT_LANES  = 4;
  localparam int DEFAULT_DEPTH  = 2;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_lanes_stage.sv
// rtl/pipe_lanes_stage.sv - one elastic stage holding valid, lane data and lane mask
module pipe_lanes_stage
  import pcie_pl_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES,
  parameter int WIDTH = LANE_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   load,
  input  logic                   adv,
  input  logic [LANES*WIDTH-1:0] d_in,
  input  logic [LANES-1:0]       m_in,
  output logic                   v,
  output logic [LANES*WIDTH-1:0] d,
  output logic [LANES-1:0]       m
);

  // Flush only drops the valid bit; payload registers keep their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= 1'b0;
      d <= '0;
      m <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (adv) begin
      v <= load;
      if (load) begin
        d <= d_in;
        m <= m_in;
      end
    end
  end

endmodule

// File: rtl/pipe_lanes_elastic.sv
// rtl/pipe_lanes_elastic.sv - DEPTH-stage elastic multi-lane pipe; PIPE_LANES_OCC_EN adds an occupancy output
module pipe_lanes_elastic
  import pcie_pl_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES,
  parameter int WIDTH = LANE_W_DEFAULT,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_lane_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_lane_en
`ifdef PIPE_LANES_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  logic [DEPTH-1:0]       v;
  logic [LANES*WIDTH-1:0] d [DEPTH];
  logic [LANES-1:0]       m [DEPTH];
  logic [DEPTH:0]         adv;
  logic [LANES*WIDTH-1:0] in_masked;
  logic                   accept;

  // A stage may move whenever any slot at or beyond it is empty, or the sink takes a word.
  always_comb begin
    logic chain;
    chain      = out_ready;
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      chain  = !v[s] | chain;
      adv[s] = chain;
    end
  end

  assign in_ready = adv[0] & !flush & !reset;
  assign accept   = in_valid & in_ready;

  always_comb begin
    in_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_lane_en[i]) begin
        in_masked[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    logic [LANES*WIDTH-1:0] d_src;
    logic [LANES-1:0]       m_src;
    logic                   ld;

    if (s == 0) begin : g_head
      assign d_src = in_masked;
      assign m_src = in_lane_en;
      assign ld    = accept;
    end else begin : g_body
      assign d_src = d[s-1];
      assign m_src = m[s-1];
      assign ld    = v[s-1];
    end

    pipe_lanes_stage #(
      .LANES(LANES),
      .WIDTH(WIDTH)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (ld),
      .adv   (adv[s]),
      .d_in  (d_src),
      .m_in  (m_src),
      .v     (v[s]),
      .d     (d[s]),
      .m     (m[s])
    );
  end

  // Flush masks the output valid so no word is handed off in the flush cycle.
  assign out_valid   = v[DEPTH-1] & !flush;
  assign out_data    = d[DEPTH-1];
  assign out_lane_en = m[DEPTH-1];

`ifdef PIPE_LANES_OCC_EN
  localparam int OW = occ_width(DEPTH);
  logic emit;
  assign emit = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ <= '0;
    end else begin
      occ <= occ + OW'(accept) - OW'(emit);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_lanes_elastic.sv
// tb/tb_pipe_lanes_elastic.sv - checks three pipe_lanes_elastic sizes against a word-position queue model
module tb_pipe_lanes_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, iv, ordy;
  logic [31:0] idata;
  logic [3:0]  ien;

  logic        a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
  logic [31:0] a_od, b_od;
  logic [3:0]  a_om, b_om;
  logic [0:0]  c_od, c_om;
`ifdef PIPE_LANES_OCC_EN
  logic [1:0]  a_occ;
  logic [2:0]  b_occ;
  logic [0:0]  c_occ;
`endif

  pipe_lanes_elastic #(.LANES(4), .WIDTH(8), .DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv), .in_ready(a_ir),
    .in_data(idata), .in_lane_en(ien), .out_valid(a_ov), .out_ready(ordy),
    .out_data(a_od), .out_lane_en(a_om)
`ifdef PIPE_LANES_OCC_EN
    , .occ(a_occ)
`endif
  );

  pipe_lanes_elastic #(.LANES(4), .WIDTH(8), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv), .in_ready(b_ir),
    .in_data(idata), .in_lane_en(ien), .out_valid(b_ov), .out_ready(ordy),
    .out_data(b_od), .out_lane_en(b_om)
`ifdef PIPE_LANES_OCC_EN
    , .occ(b_occ)
`endif
  );

  pipe_lanes_elastic #(.LANES(1), .WIDTH(1), .DEPTH(1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv), .in_ready(c_ir),
    .in_data(idata[0:0]), .in_lane_en(ien[0:0]), .out_valid(c_ov), .out_ready(ordy),
    .out_data(c_od), .out_lane_en(c_om)
`ifdef PIPE_LANES_OCC_EN
    , .occ(c_occ)
`endif
  );

  // Model: each pipe is an ordered list of words, each tagged with its slot (0 = input side).
  typedef struct {
    logic [31:0] d;
    logic [3:0]  m;
    int          pos;
  } ent_t;

  ent_t e [3][6];
  int   n [3];
  int   dk [3] = '{2, 4, 1};
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_data(input int k, input logic [31:0] dd, input logic [3:0] en);
    logic [31:0] r;
    r = '0;
    if (k == 2) begin
      r[0] = dd[0] & en[0];
    end else begin
      for (int l = 0; l < 4; l++) if (en[l]) r[l*8 +: 8] = dd[l*8 +: 8];
    end
    return r;
  endfunction

  // Called right after a negedge with inputs already driven; returns at the next negedge.
  task automatic cyc();
    bit          acc [3];
    bit          emt [3];
    bit          exir, exov;
    logic        gir, gov;
    logic [31:0] god;
    logic [3:0]  gom;
    int          go;
    int          lim, np;
    #1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin gir = a_ir; gov = a_ov; god = a_od; gom = a_om; end
        1: begin gir = b_ir; gov = b_ov; god = b_od; gom = b_om; end
        default: begin gir = c_ir; gov = c_ov; god = {31'b0, c_od}; gom = {3'b0, c_om}; end
      endcase
      exir = !reset && !flush && (ordy || n[k] < dk[k]);
      exov = !flush && n[k] > 0 && e[k][0].pos == dk[k] - 1;
      chk($sformatf("m%0d.in_ready", k), 32'(gir), 32'(exir));
      chk($sformatf("m%0d.out_valid", k), 32'(gov), 32'(exov));
      if (exov) begin
        chk($sformatf("m%0d.out_data", k), god, e[k][0].d);
        chk($sformatf("m%0d.out_lane_en", k), 32'(gom), 32'(e[k][0].m));
      end
`ifdef PIPE_LANES_OCC_EN
      case (k)
        0: go = int'(a_occ);
        1: go = int'(b_occ);
        default: go = int'(c_occ);
      endcase
      chk($sformatf("m%0d.occ", k), 32'(go), 32'(n[k]));
`else
      go = 0;
`endif
      acc[k] = iv && exir;
      emt[k] = exov && ordy;
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (reset || flush) begin
        n[k] = 0;
      end else begin
        if (emt[k]) begin
          for (int i = 1; i < n[k]; i++) e[k][i-1] = e[k][i];
          n[k]--;
        end
        for (int i = 0; i < n[k]; i++) begin
          lim = (i == 0) ? dk[k] - 1 : e[k][i-1].pos - 1;
          np  = e[k][i].pos + 1;
          e[k][i].pos = (np > lim) ? lim : np;
        end
        if (acc[k]) begin
          e[k][n[k]].d   = mask_data(k, idata, ien);
          e[k][n[k]].m   = (k == 2) ? {3'b0, ien[0]} : ien;
          e[k][n[k]].pos = 0;
          n[k]++;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b1; idata = '0; ien = '0;
    for (int k = 0; k < 3; k++) n[k] = 0;
    @(negedge clk);
    chk("rst.a_out_valid", 32'(a_ov), 32'd0);
    chk("rst.a_out_data", a_od, 32'd0);
    chk("rst.a_out_lane_en", 32'(a_om), 32'd0);
    chk("rst.c_out_data", 32'(c_od), 32'd0);
    cyc();
    reset = 1'b0;
    #1 chk("rst_release.a_in_ready", 32'(a_ir), 32'd1);

    // Streaming two words with out_ready high.
    iv = 1'b1; idata = 32'h03020100; ien = 4'hF;
    cyc();
    chk("stream.a_not_yet", 32'(a_ov), 32'd0);
    idata = 32'h07060504;
    cyc();
    iv = 1'b0;
    chk("stream.a_w0_valid", 32'(a_ov), 32'd1);
    chk("stream.a_w0", a_od, 32'h03020100);
    cyc();
    chk("stream.a_w1", a_od, 32'h07060504);
    cyc();
    chk("stream.a_empty", 32'(a_ov), 32'd0);
    repeat (3) cyc();

    // Backpressure: A fills after two accepts and holds its head word.
    ordy = 1'b0; iv = 1'b1; idata = 32'h03020100;
    cyc();
    idata = 32'h07060504;
    cyc();
    idata = 32'h0B0A0908;
    #1 chk("bp.a_in_ready_low", 32'(a_ir), 32'd0);
    repeat (3) cyc();
    chk("bp.a_hold_valid", 32'(a_ov), 32'd1);
    chk("bp.a_hold_data", a_od, 32'h03020100);
    ordy = 1'b1;
    cyc();
    iv = 1'b0;
    chk("bp.a_w1", a_od, 32'h07060504);
    cyc();
    chk("bp.a_w2", a_od, 32'h0B0A0908);
    cyc();
    chk("bp.a_drained", 32'(a_ov), 32'd0);
    repeat (4) cyc();

    // Lane mask.
    iv = 1'b1; idata = 32'hAABBCCDD; ien = 4'b0101;
    cyc();
    chk("mask.c_data", 32'(c_od), 32'd1);
    iv = 1'b0; ien = 4'hF;
    cyc();
    chk("mask.a_data", a_od, 32'h00BB00DD);
    chk("mask.a_lane_en", 32'(a_om), 32'h5);
    repeat (3) cyc();

    // Bubble collapse on the 4-deep pipe.
    iv = 1'b1; idata = 32'h11223344;
    cyc();
    iv = 1'b0;
    repeat (3) cyc();
    chk("bub.b_x1_valid", 32'(b_ov), 32'd1);
    chk("bub.b_x1", b_od, 32'h11223344);
    ordy = 1'b0; iv = 1'b1; idata = 32'h55667788;
    cyc();
    iv = 1'b0;
    repeat (3) cyc();
    chk("bub.b_hold", b_od, 32'h11223344);
    ordy = 1'b1;
    cyc();
    chk("bub.b_x2_valid", 32'(b_ov), 32'd1);
    chk("bub.b_x2_next", b_od, 32'h55667788);
    cyc();
    chk("bub.b_empty", 32'(b_ov), 32'd0);

    // Flush a full pipe.
    ordy = 1'b0; iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idata = 32'h10203040 + 32'(i);
      cyc();
    end
    iv = 1'b0; flush = 1'b1;
    #1 chk("flush.a_ov_forced", 32'(a_ov), 32'd0);
    chk("flush.a_ir_low", 32'(a_ir), 32'd0);
    cyc();
    flush = 1'b0;
    chk("flush.a_ov_after", 32'(a_ov), 32'd0);
    chk("flush.b_ov_after", 32'(b_ov), 32'd0);
    ordy = 1'b1; iv = 1'b1; idata = 32'hCAFEF00D;
    cyc();
    iv = 1'b0;
    chk("flush.a_lat1", 32'(a_ov), 32'd0);
    cyc();
    chk("flush.a_lat2_valid", 32'(a_ov), 32'd1);
    chk("flush.a_lat2_data", a_od, 32'hCAFEF00D);
    repeat (4) cyc();

    // Reset while words are in flight.
    iv = 1'b1; idata = 32'h12345678;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; iv = 1'b0;
    chk("midrst.a_ov", 32'(a_ov), 32'd0);
    chk("midrst.b_ov", 32'(b_ov), 32'd0);
    repeat (4) cyc();

    // DEPTH=1 single-bit pipe: accept and emit every cycle.
    iv = 1'b1; ordy = 1'b1; ien = 4'hF;
    for (int i = 0; i < 8; i++) begin
      idata = 32'(i);
      #1 chk("c1.in_ready", 32'(c_ir), 32'd1);
      cyc();
      chk("c1.out_valid", 32'(c_ov), 32'd1);
      chk("c1.out_data", 32'(c_od), 32'(i & 1));
    end

    // Mixed backpressure, gaps, masks and a flush.
    for (int i = 0; i < 60; i++) begin
      ordy  = (i % 3) != 0;
      iv    = (i % 5) != 1;
      flush = (i == 37);
      idata = (32'(i) * 32'h01010101) ^ 32'h5A3C_96E1;
      ien   = 4'(i);
      cyc();
    end
    flush = 1'b0; iv = 1'b0; ordy = 1'b1;
    repeat (6) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
